// File: rtl/leiwand_rv32_uart_tx.sv
// leiwand_rv32_uart_tx
// Wishbone slave UART transmitter. The CPU pushes bytes into a small TX FIFO;
// an 8N1 serializer drains the FIFO onto the uart_tx pin.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   wb_addr          byte address, only [3:2] decoded (SoC already gates wb_stb)
//   wb_data_in       write data
//   wb_data_out      registered read data, non-zero only while wb_ack = 1
//   wb_we            1 = write, 0 = read
//   wb_stb, wb_cyc   strobe / cycle; a request is accepted when both are 1
//   wb_ack           one-cycle acknowledge, one cycle after accept
//   wb_stall         always 0
//   data_write_size  write size in bytes (1, 2 or 4)
//   uart_tx          serial output, idles high
//
// Register map (wb_addr[3:2]):
//   0 TXDATA  write pushes [7:0], reads 0
//   1 STATUS  {level[15:8], overflow[3], busy[2], empty[1], full[0]};
//             writing bit3 = 1 clears the sticky overflow flag
//   2 BAUD    [15:0] divisor, bit period = divisor + 1 clocks; 1-byte writes ignored
//   3         reserved, reads 0
//
// Handshake: every cycle with wb_cyc & wb_stb = 1 is an accepted request.
// Writes take effect on that accept edge; wb_ack and wb_data_out are
// registered on the same edge and therefore appear exactly one cycle later.
// There is no back-pressure, so back-to-back strobes get back-to-back acks.

module leiwand_rv32_uart_tx #(
    parameter int MEM_WIDTH   = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int DEFAULT_DIV = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MEM_WIDTH-1:0] wb_addr,
    input  logic [MEM_WIDTH-1:0] wb_data_in,
    output logic [MEM_WIDTH-1:0] wb_data_out,
    input  logic                 wb_we,
    input  logic                 wb_stb,
    output logic                 wb_ack,
    input  logic                 wb_cyc,
    output logic                 wb_stall,
    input  logic [2:0]           data_write_size,
    output logic                 uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_d;
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  level;
    logic           overflow;
    logic [15:0]    baud;
    logic [15:0]    div_lat, div_d;
    logic [15:0]    cnt, cnt_d;
    logic [2:0]     bit_idx, bit_d;
    logic [7:0]     shreg, sh_d;
    logic           pop;

    logic           accept, push_req, push;
    logic           fifo_full, fifo_empty;
    logic [1:0]     reg_sel;
    logic [MEM_WIDTH-1:0] rd_data;
    logic           unused_bits;

    assign accept     = wb_cyc & wb_stb;
    assign reg_sel    = wb_addr[3:2];
    assign push_req   = accept & wb_we & (reg_sel == 2'd0);
    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    // A full FIFO still takes the byte when the serializer pops in the same cycle.
    assign push       = push_req & (~fifo_full | pop);
    assign wb_stall   = 1'b0;
    assign unused_bits = ^{wb_addr[MEM_WIDTH-1:4], wb_addr[1:0], wb_data_in[MEM_WIDTH-1:16]};

    // Read mux, sampled into wb_data_out on the accept edge.
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd1: begin
                rd_data[0]      = fifo_full;
                rd_data[1]      = fifo_empty;
                rd_data[2]      = (state != IDLE);
                rd_data[3]      = overflow;
                rd_data[8 +: LW] = level;
            end
            2'd2:    rd_data[15:0] = baud;
            default: rd_data = '0;
        endcase
    end

    // FIFO storage has no reset; validity is tracked by level and pointers.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= wb_data_in[7:0];
    end

    // Serializer next-state logic. cnt counts div..0 within each bit; the
    // divisor is latched at pop so a BAUD write never disturbs a running frame.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_idx;
        sh_d    = shreg;
        div_d   = div_lat;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_mem[rd_ptr];
                    div_d   = baud;
                    cnt_d   = baud;
                    state_d = START;
                end
            end
            START: begin
                if (cnt == '0) begin
                    cnt_d   = div_lat;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    cnt_d = div_lat;
                    if (bit_idx == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_idx + 1'b1;
                        sh_d  = {1'b0, shreg[7:1]};
                    end
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            STOP: begin
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            div_lat     <= 16'(DEFAULT_DIV);
            baud        <= 16'(DEFAULT_DIV);
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            overflow    <= 1'b0;
            wb_ack      <= 1'b0;
            wb_data_out <= '0;
            uart_tx     <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_d;
            shreg   <= sh_d;
            div_lat <= div_d;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (push_req && !push)
                overflow <= 1'b1;
            else if (accept && wb_we && reg_sel == 2'd1 && wb_data_in[3])
                overflow <= 1'b0;

            if (accept && wb_we && reg_sel == 2'd2 && data_write_size >= 3'd2)
                baud <= wb_data_in[15:0];

            wb_ack      <= accept;
            wb_data_out <= (accept && !wb_we) ? rd_data : '0;

            // Line output is a registered decode of the current state, so the
            // pin is glitch-free and lags the FSM by one clock.
            case (state)
                START:   uart_tx <= 1'b0;
                DATA:    uart_tx <= shreg[0];
                default: uart_tx <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_leiwand_rv32_uart_tx.sv
module tb_leiwand_rv32_uart_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_data_in = '0;
    logic [31:0] wb_data_out;
    logic        wb_we = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_ack;
    logic        wb_cyc = 1'b0;
    logic        wb_stall;
    logic [2:0]  data_write_size = 3'd4;
    logic        uart_tx;

    int n_cmp = 0;
    int n_fail = 0;

    leiwand_rv32_uart_tx #(
        .MEM_WIDTH(32), .FIFO_DEPTH(8), .DEFAULT_DIV(12)
    ) dut (
        .clk(clk), .reset(reset), .wb_addr(wb_addr), .wb_data_in(wb_data_in),
        .wb_data_out(wb_data_out), .wb_we(wb_we), .wb_stb(wb_stb), .wb_ack(wb_ack),
        .wb_cyc(wb_cyc), .wb_stall(wb_stall), .data_write_size(data_write_size),
        .uart_tx(uart_tx)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_ack", {31'b0, wb_ack}, 32'd0);
        check("rst_data", wb_data_out, 32'd0);
        check("rst_stall", {31'b0, wb_stall}, 32'd0);
        reset = 1'b0;
    endtask

    // Driver: one single-cycle request, ack sampled 1 time unit after the accept edge.
    task automatic xfer(input logic we, input logic [1:0] addr, input logic [31:0] data,
                        input logic [2:0] size, input string name, output logic [31:0] rdata);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_addr = {28'b0, addr, 2'b00}; wb_data_in = data; data_write_size = size;
        @(posedge clk);
        #1;
        check({name, "_ack"}, {31'b0, wb_ack}, 32'd1);
        rdata = wb_data_out;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic read_chk(input logic [1:0] addr, input logic [31:0] exp, input string name);
        logic [31:0] r;
        xfer(1'b0, addr, 32'd0, 3'd4, name, r);
        check(name, r, exp);
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [31:0] data,
                             input logic [2:0] size, input string name);
        logic [31:0] r;
        xfer(1'b1, addr, data, size, name, r);
    endtask

    // Back-to-back TXDATA writes with no idle cycle; byte i = base + i*step.
    task automatic burst(input int n, input logic [7:0] base, input logic [7:0] step, input string name);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_addr = 32'd0; wb_data_in = {24'b0, base}; data_write_size = 3'd1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_ack%0d", name, i), {31'b0, wb_ack}, 32'd1);
            if (i < n - 1) wb_data_in = {24'b0, 8'(base + 8'(i + 1) * step)};
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    // Waits for the start bit (bounded), checks the gap, then every clock of
    // all ten bit periods against the expected 8N1 waveform.
    task automatic check_frame(input logic [7:0] b, input int div, input int exp_wait, input string name);
        int w;
        int bad;
        logic e;
        w = 0;
        do begin
            @(posedge clk);
            #1;
            w++;
        end while (uart_tx !== 1'b0 && w < 3000);
        if (uart_tx !== 1'b0) begin
            check({name, "_start_timeout"}, {31'b0, uart_tx}, 32'd0);
            return;
        end
        if (exp_wait > 0) check({name, "_gap"}, w, exp_wait);
        for (int k = 0; k < 10; k++) begin
            e = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            bad = 0;
            for (int c = 0; c <= div; c++) begin
                if (k != 0 || c != 0) begin
                    @(posedge clk);
                    #1;
                end
                if (uart_tx !== e) bad++;
            end
            check($sformatf("%s_bit%0d_badclk", name, k), bad, 0);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [2:0]  size;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] r;
        int bad;

        vecs[0]  = '{1'b0, 2'd1, 32'h0,         3'd4, 32'h0000_0002};
        vecs[1]  = '{1'b0, 2'd2, 32'h0,         3'd4, 32'd12};
        vecs[2]  = '{1'b0, 2'd0, 32'h0,         3'd4, 32'h0};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,         3'd4, 32'h0};
        vecs[4]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 3'd4, 32'h0};
        vecs[5]  = '{1'b0, 2'd2, 32'h0,         3'd4, 32'd12};
        vecs[6]  = '{1'b1, 2'd2, 32'd3,         3'd1, 32'h0};
        vecs[7]  = '{1'b0, 2'd2, 32'h0,         3'd4, 32'd12};
        vecs[8]  = '{1'b1, 2'd2, 32'h1234_0005, 3'd2, 32'h0};
        vecs[9]  = '{1'b0, 2'd2, 32'h0,         3'd4, 32'd5};
        vecs[10] = '{1'b1, 2'd2, 32'd3,         3'd4, 32'h0};
        vecs[11] = '{1'b0, 2'd2, 32'h0,         3'd4, 32'd3};
        vecs[12] = '{1'b1, 2'd1, 32'hFFFF_FFFF, 3'd4, 32'h0};
        vecs[13] = '{1'b0, 2'd1, 32'h0,         3'd4, 32'h0000_0002};
        vecs[14] = '{1'b1, 2'd2, 32'd12,        3'd4, 32'h0};
        vecs[15] = '{1'b0, 2'd2, 32'h0,         3'd4, 32'd12};

        // Reset state and register map
        do_reset();
        for (int i = 0; i < 16; i++) begin
            xfer(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].size, $sformatf("vec%0d", i), r);
            if (!vecs[i].we) check($sformatf("vec%0d_rd", i), r, vecs[i].exp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ack_drop", i), {31'b0, wb_ack}, 32'd0);
            check($sformatf("vec%0d_data_drop", i), wb_data_out, 32'd0);
        end

        // Single frame 0xA5 at divisor 12, busy visible mid-frame
        fork
            begin
                write_reg(2'd0, 32'h0000_00A5, 3'd4, "a5_wr");
                repeat (30) @(posedge clk);
                read_chk(2'd1, 32'h0000_0006, "a5_busy");
            end
            check_frame(8'hA5, 12, 3, "a5");
        join
        read_chk(2'd1, 32'h0000_0002, "a5_done");

        // BAUD change mid-frame only affects the next frame
        fork
            begin
                write_reg(2'd0, 32'h3C, 3'd1, "bd_wr0");
                write_reg(2'd0, 32'h81, 3'd1, "bd_wr1");
                repeat (20) @(posedge clk);
                write_reg(2'd2, 32'd3, 3'd4, "bd_baud");
            end
            begin
                check_frame(8'h3C, 12, 3, "bd_f0");
                check_frame(8'h81, 3, 2, "bd_f1");
            end
        join
        write_reg(2'd2, 32'd12, 3'd4, "bd_restore");

        // Nine back-to-back pushes while the first byte is on the line
        fork
            begin
                burst(9, 8'h11, 8'h1D, "b9");
                read_chk(2'd1, 32'h0000_0805, "b9_full");
            end
            for (int i = 0; i < 9; i++)
                check_frame(8'(8'h11 + 8'(i) * 8'h1D), 12, (i == 0) ? 3 : 2, $sformatf("b9_f%0d", i));
        join
        read_chk(2'd1, 32'h0000_0002, "b9_done");

        // Overflow with a very slow divisor
        write_reg(2'd2, 32'h0000_FFFF, 3'd4, "ov_baud");
        burst(10, 8'h40, 8'h01, "ov");
        read_chk(2'd1, 32'h0000_080D, "ov_set");
        write_reg(2'd1, 32'h0000_0007, 3'd4, "ov_nclr");
        read_chk(2'd1, 32'h0000_080D, "ov_kept");
        write_reg(2'd1, 32'h0000_0008, 3'd4, "ov_clr");
        read_chk(2'd1, 32'h0000_0805, "ov_cleared");
        do_reset();
        read_chk(2'd1, 32'h0000_0002, "rst2_status");
        read_chk(2'd2, 32'd12, "rst2_baud");

        // Reset during data bit 4 of 0xE0 with a second byte pending
        write_reg(2'd0, 32'hE0, 3'd1, "mr_wr0");
        write_reg(2'd0, 32'h77, 3'd1, "mr_wr1");
        repeat (70) @(posedge clk);
        #0;
        check("mr_bit4", {31'b0, uart_tx}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mr_tx_high", {31'b0, uart_tx}, 32'd1);
        reset = 1'b0;
        read_chk(2'd1, 32'h0000_0002, "mr_status");
        bad = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (uart_tx !== 1'b1) bad++;
        end
        check("mr_no_frame", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
